// File: rtl/psum_row_ctrl_pkg.sv
// Shared definitions for the polar-code partial-sum row controller.
package psum_row_ctrl_pkg;

   // Default code length: n = log2(N), N = 2**n.
   localparam int PSUM_LOG2_N = 2;
   localparam int PSUM_N      = 2 ** PSUM_LOG2_N;

   // Controller phases: waiting for start, accepting bits, one-cycle completion.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } psum_state_e;

   // Code length for a given log2 length.
   function automatic int code_len(input int log2_n);
      return 1 << log2_n;
   endfunction

endpackage

// File: rtl/psum_row_gen.sv
// Generator-matrix row walker: starts at row 0 of F^{(x)n} (bit0 only) and
// steps to the next row on each advance. Row i bit j is binom(i,j) mod 2,
// which is exactly Pascal's rule over GF(2): row[j] ^= row[j-1].
module psum_row_gen #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         init,
   input  logic         adv,
   output logic [N-1:0] row
);

   localparam logic [N-1:0] ROW_ONE = N'(1);

   logic [N-1:0] row_q;
   logic [N-1:0] row_d;

   // Next row: reinit wins over advance; bit0 of every row is always 1.
   always_comb begin
      row_d = row_q;
      if (init) begin
         row_d = ROW_ONE;
      end else if (adv) begin
         row_d[0] = 1'b1;
         for (int j = 1; j < N; j++) begin
            row_d[j] = row_q[j] ^ row_q[j-1];
         end
      end
   end

   // Row register with synchronous active-low reset back to row 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         row_q <= ROW_ONE;
      end else begin
         row_q <= row_d;
      end
   end

   assign row = row_q;

endmodule

// File: rtl/psum_row_ctrl.sv
// Partial-sum controller for a successive-cancellation polar decoder.
// Accumulates x = u[0..idx-1] * G_N over GF(2) as decoded bits arrive.
//
// Handshake: a bit is accepted on a rising edge where u_valid && u_ready,
// and start is low; u_ready is a registered flag that is high exactly while
// the controller is in RUN. The producer may hold u_valid as long as it likes;
// nothing is consumed unless u_ready is high. start always wins over u_valid,
// so a bit presented together with start is dropped.
module psum_row_ctrl
   import psum_row_ctrl_pkg::*;
#(
   parameter int n = PSUM_LOG2_N
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             u_valid,
   input  logic             u_bit,
   output logic             u_ready,
   output logic [2**n-1:0]  row,
   output logic [n-1:0]     idx,
   output logic [2**n-1:0]  psum,
   output logic             psum_vld,
   output logic             busy,
   output logic             done,
   output logic [1:0]       state_dbg
);

   localparam int N = code_len(n);

   localparam logic [n-1:0] IDX_LAST = n'(N - 1);
   localparam logic [n-1:0] IDX_ONE  = n'(1);

   psum_state_e    state_q,    state_d;
   logic [n-1:0]   idx_q,      idx_d;
   logic [N-1:0]   psum_q,     psum_d;
   logic           psum_vld_q, psum_vld_d;
   logic           done_q,     done_d;
   logic           busy_q,     busy_d;
   logic           u_ready_q,  u_ready_d;

   logic           accept;
   logic           row_init;
   logic [N-1:0]   row_w;

   // A bit is consumed only in RUN and never alongside a (re)start.
   assign accept   = (state_q == ST_RUN) && u_valid && !start;
   assign row_init = start;

   psum_row_gen #(
      .N (N)
   ) u_row_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .init  (row_init),
      .adv   (accept),
      .row   (row_w)
   );

   // Next-state, counter, accumulator and registered-output computation.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      psum_d     = psum_q;
      psum_vld_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               idx_d   = '0;
               psum_d  = '0;
            end
         end
         ST_RUN: begin
            if (start) begin
               // Mid-codeword abort: restart cleanly, stay in RUN.
               idx_d  = '0;
               psum_d = '0;
            end else if (u_valid) begin
               psum_d     = psum_q ^ (u_bit ? row_w : '0);
               psum_vld_d = 1'b1;
               if (idx_q == IDX_LAST) begin
                  state_d = ST_DONE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + IDX_ONE;
               end
            end
         end
         ST_DONE: begin
            // Final codeword stays in psum until the next start clears it.
            if (start) begin
               state_d = ST_RUN;
               idx_d   = '0;
               psum_d  = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d    = (state_d == ST_RUN);
      u_ready_d = (state_d == ST_RUN);
      done_d    = (state_d == ST_DONE);
   end

   // State and registered outputs; reset dominates start and u_valid.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         psum_q     <= '0;
         psum_vld_q <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         u_ready_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         psum_q     <= psum_d;
         psum_vld_q <= psum_vld_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         u_ready_q  <= u_ready_d;
      end
   end

   assign u_ready   = u_ready_q;
   assign row       = row_w;
   assign idx       = idx_q;
   assign psum      = psum_q;
   assign psum_vld  = psum_vld_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign state_dbg = state_q;

endmodule

// File: doc/psum_row_ctrl.md
PSUM_ROW_CTRL -- requirements
Module: psum_row_ctrl

Interface
REQ-001 Parameter: n, default 2, log2 of code length; N = 2**n.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  begin a new codeword; sampled every cycle.
REQ-005 u_valid  input  1  decoded bit u_i present.
REQ-006 u_bit  input  1  value of decoded bit u_i.
REQ-007 u_ready  output  1  controller accepts u_bit this cycle.
REQ-008 row  output  N  current generator-matrix row G_N[idx].
REQ-009 idx  output  n  index of the next bit to be accepted.
REQ-010 psum  output  N  running partial-sum vector x = u[0..idx-1]·G_N over GF(2).
REQ-011 psum_vld  output  1  one-cycle pulse; psum updated by the previous accept.
REQ-012 busy  output  1  high in RUN.
REQ-013 done  output  1  one-cycle pulse after the N-th bit is accepted.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE; the encoding is free.
REQ-015 IDLE: u_ready=0, busy=0; start=1 -> RUN, with row=1 (bit0 only), psum=0, idx=0.
REQ-016 RUN: u_ready=1, busy=1; an accept is u_valid && u_ready.
REQ-017 On an accept: psum <= psum ^ (u_bit ? row : 0); row[j] <= row[j]^row[j-1] for j=1..N-1, row[0] held at 1; idx <= idx+1; psum_vld=1 in the next cycle.
REQ-018 Row i bit j SHALL equal binom(i,j) mod 2, i.e. ((i & j) == j); this matches Arikan F^{⊗n} row i.
REQ-019 No accept (u_valid=0): row, psum and idx hold.
REQ-020 An accept with idx==N-1 -> DONE; idx wraps to 0; psum holds the final codeword.
REQ-021 DONE lasts exactly one cycle: done=1, u_ready=0 -> IDLE; psum stays stable until the next start.
REQ-022 start in RUN (mid-codeword abort) SHALL reinitialise as in REQ-015, stay in RUN, and discard any simultaneous u_valid.
REQ-023 start in DONE SHALL be honoured: DONE -> RUN with reinitialisation, and done still pulses.
REQ-024 Latency: accept at cycle t -> psum, row and idx updated and visible at t+1.
REQ-025 All GF(2) arithmetic is bitwise XOR; there is no carry and no width growth.

Reset
REQ-026 rst_n=0 at a clock edge -> state IDLE, row=1, psum=0, idx=0, psum_vld=0, done=0, busy=0, u_ready=0.
REQ-027 Reset SHALL take priority over start and u_valid, including mid-RUN.
REQ-028 Outputs SHALL be defined from the first edge with rst_n=0; no reliance on initial blocks.

Structure
REQ-029 The shared package SHALL hold the FSM state typedef and the N = 2**n localparam.
REQ-030 The row-advance register (REQ-017 row update plus reinit) SHALL be one sub-module, psum_row_gen, with clk, rst_n, init, adv and row ports.
REQ-031 The FSM, idx counter and psum accumulator stay in psum_row_ctrl.

Verification (n=2, N=4)
REQ-032 Reset, start, u=1,0,1,1 on consecutive cycles -> rows seen 0x1, 0x3, 0x5, 0xF; final psum=0xB; done pulses one cycle after the 4th accept.
REQ-033 start, u=1,1,1,1 -> psum sequence 0x1, 0x2, 0x7, 0x8; psum_vld pulses 4 times.
REQ-034 start, u_valid toggled 1,0,0,1,1,0,1 with u=1 each valid -> psum/idx hold on idle cycles; final psum=0x8.
REQ-035 start, accept 2 bits, then start with u_valid=1 -> idx=0, psum=0, row=0x1 next cycle; the bit is discarded.
REQ-036 rst_n=0 during RUN after 3 accepts -> next cycle IDLE, all outputs per REQ-026; u_ready=0 until a new start.
